// File: rtl/l2_dual_port_arbiter.sv
// Shares two contiguous L2 ports among NumReq requesters: per-port round-robin,
// address steering, in-order response routing via per-port ID FIFOs.
module l2_dual_port_arbiter #(
  parameter int unsigned           NumReq    = 4,
  parameter int unsigned           AddrWidth = 48,
  parameter int unsigned           DataWidth = 64,
  parameter int unsigned           BeWidth   = DataWidth / 8,
  parameter logic [AddrWidth-1:0]  Port0Base = 48'h7800_0000,
  parameter logic [AddrWidth-1:0]  PortSize  = 48'h0002_0000
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_i,
  input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
  input  logic [NumReq-1:0]             req_we_i,
  input  logic [NumReq*DataWidth-1:0]   req_wdata_i,
  input  logic [NumReq*BeWidth-1:0]     req_be_i,
  output logic [NumReq-1:0]             gnt_o,
  output logic [NumReq-1:0]             rsp_valid_o,
  output logic [NumReq*DataWidth-1:0]   rsp_rdata_o,
  output logic [NumReq-1:0]             rsp_err_o,
  output logic [1:0]                    mem_req_o,
  input  logic [1:0]                    mem_gnt_i,
  output logic [2*AddrWidth-1:0]        mem_addr_o,
  output logic [1:0]                    mem_we_o,
  output logic [2*DataWidth-1:0]        mem_wdata_o,
  output logic [2*BeWidth-1:0]          mem_be_o,
  input  logic [1:0]                    mem_rvalid_i,
  input  logic [2*DataWidth-1:0]        mem_rdata_i
);

  localparam int unsigned IdW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned CntW = $clog2(NumReq + 1);
  localparam logic [AddrWidth-1:0] Port1Base = Port0Base + PortSize;
  localparam logic [AddrWidth-1:0] PortEnd   = Port1Base + PortSize;

  typedef logic [IdW-1:0] id_t;
  localparam id_t LastId = id_t'(NumReq - 1);

  logic [AddrWidth-1:0] w_addr  [NumReq];
  logic [DataWidth-1:0] w_wdata [NumReq];
  logic [BeWidth-1:0]   w_be    [NumReq];
  logic [DataWidth-1:0] w_rdata [NumReq];

  logic [NumReq-1:0] w_hit0, w_hit1, w_err_sel, w_err_gnt;
  logic [NumReq-1:0] w_elig [2];
  id_t               w_win  [2];
  id_t               w_head [2];
  logic [1:0]        w_found, w_hs, w_pop;

  logic [NumReq-1:0] r_outst;
  logic [NumReq-1:0] r_err_rsp;
  id_t               r_ptr  [2];
  id_t               r_fifo [2][NumReq];
  id_t               r_wptr [2];
  id_t               r_rptr [2];
  logic [CntW-1:0]   r_cnt  [2];

  function automatic id_t inc_id(input id_t v);
    return (v == LastId) ? '0 : v + 1'b1;
  endfunction

  for (genvar k = 0; k < NumReq; k++) begin : g_unpack
    assign w_addr[k]  = req_addr_i[k*AddrWidth +: AddrWidth];
    assign w_wdata[k] = req_wdata_i[k*DataWidth +: DataWidth];
    assign w_be[k]    = req_be_i[k*BeWidth +: BeWidth];
    assign rsp_rdata_o[k*DataWidth +: DataWidth] = w_rdata[k];
  end

  always_comb begin
    w_hit0    = '0;
    w_hit1    = '0;
    w_err_sel = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (w_addr[k] >= Port0Base && w_addr[k] < Port1Base)    w_hit0[k]    = 1'b1;
      else if (w_addr[k] >= Port1Base && w_addr[k] < PortEnd) w_hit1[k]    = 1'b1;
      else                                                    w_err_sel[k] = 1'b1;
    end
    w_elig[0] = req_i & ~r_outst & w_hit0;
    w_elig[1] = req_i & ~r_outst & w_hit1;
    w_err_gnt = req_i & ~r_outst & w_err_sel;
  end

  // Round-robin: first eligible index at or after the pointer, wrapping.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_win[p]   = '0;
      w_found[p] = 1'b0;
      for (int i = 0; i < NumReq; i++) begin
        int unsigned idx;
        idx = (int'(r_ptr[p]) + i) % NumReq;
        if (!w_found[p] && w_elig[p][idx]) begin
          w_found[p] = 1'b1;
          w_win[p]   = id_t'(idx);
        end
      end
      w_hs[p]   = w_found[p] & mem_gnt_i[p];
      w_head[p] = r_fifo[p][r_rptr[p]];
      w_pop[p]  = mem_rvalid_i[p] && (r_cnt[p] != '0);
    end
  end

  assign mem_req_o = w_found;

  for (genvar p = 0; p < 2; p++) begin : g_port
    assign mem_addr_o[p*AddrWidth +: AddrWidth] =
      w_addr[w_win[p]] - ((p == 0) ? Port0Base : Port1Base);
    assign mem_we_o[p]                          = req_we_i[w_win[p]];
    assign mem_wdata_o[p*DataWidth +: DataWidth] = w_wdata[w_win[p]];
    assign mem_be_o[p*BeWidth +: BeWidth]        = w_be[w_win[p]];

    a_no_rvalid_when_empty: assert property (
      @(posedge clk_i) disable iff (!rst_ni) mem_rvalid_i[p] |-> (r_cnt[p] != '0));
  end

  always_comb begin
    gnt_o = w_err_gnt;
    for (int p = 0; p < 2; p++) begin
      if (w_hs[p]) gnt_o[w_win[p]] = 1'b1;
    end
  end

  // Error responses come from the register; port responses bypass combinationally.
  always_comb begin
    rsp_valid_o = r_err_rsp;
    rsp_err_o   = r_err_rsp;
    for (int k = 0; k < NumReq; k++) w_rdata[k] = '0;
    for (int p = 0; p < 2; p++) begin
      if (w_pop[p]) begin
        rsp_valid_o[w_head[p]] = 1'b1;
        w_rdata[w_head[p]]     = mem_rdata_i[p*DataWidth +: DataWidth];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outst   <= '0;
      r_err_rsp <= '0;
      for (int p = 0; p < 2; p++) begin
        r_ptr[p]  <= '0;
        r_wptr[p] <= '0;
        r_rptr[p] <= '0;
        r_cnt[p]  <= '0;
        for (int i = 0; i < NumReq; i++) r_fifo[p][i] <= '0;
      end
    end else begin
      r_outst   <= (r_outst | gnt_o) & ~rsp_valid_o;
      r_err_rsp <= w_err_gnt;
      for (int p = 0; p < 2; p++) begin
        if (w_hs[p]) begin
          r_ptr[p]              <= inc_id(w_win[p]);
          r_fifo[p][r_wptr[p]]  <= w_win[p];
          r_wptr[p]             <= inc_id(r_wptr[p]);
        end
        if (w_pop[p]) r_rptr[p] <= inc_id(r_rptr[p]);
        case ({w_hs[p], w_pop[p]})
          2'b10:   r_cnt[p] <= r_cnt[p] + 1'b1;
          2'b01:   r_cnt[p] <= r_cnt[p] - 1'b1;
          default: r_cnt[p] <= r_cnt[p];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_l2_dual_port_arbiter.sv
// Randomized bench for l2_dual_port_arbiter: requester agents, an in-order
// memory model per port, and a per-requester response scoreboard.
module tb_l2_dual_port_arbiter;
  localparam int N  = 4;
  localparam int AW = 48;
  localparam int DW = 64;
  localparam int BW = 8;
  localparam logic [47:0] BASE0 = 48'h7800_0000;
  localparam logic [47:0] SIZE  = 48'h0002_0000;
  localparam logic [47:0] BASE1 = BASE0 + SIZE;
  localparam logic [47:0] END1  = BASE1 + SIZE;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [N-1:0]      req_i = '0;
  logic [N*AW-1:0]   req_addr_i = '0;
  logic [N-1:0]      req_we_i = '0;
  logic [N*DW-1:0]   req_wdata_i = '0;
  logic [N*BW-1:0]   req_be_i = '0;
  logic [N-1:0]      gnt_o, rsp_valid_o, rsp_err_o;
  logic [N*DW-1:0]   rsp_rdata_o;
  logic [1:0]        mem_req_o, mem_we_o;
  logic [1:0]        mem_gnt_i = '0;
  logic [1:0]        mem_rvalid_i = '0;
  logic [2*AW-1:0]   mem_addr_o;
  logic [2*DW-1:0]   mem_wdata_o;
  logic [2*BW-1:0]   mem_be_o;
  logic [2*DW-1:0]   mem_rdata_i = '0;

  l2_dual_port_arbiter #(
    .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .BeWidth(BW),
    .Port0Base(BASE0), .PortSize(SIZE)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_i(req_i), .req_addr_i(req_addr_i), .req_we_i(req_we_i),
    .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // knobs set by the main sequence
  int gnt_pct = 70, lat_max = 6, req_pct = 40, force_port = -1;
  bit stall0 = 1'b0, stop_new = 1'b0, tb_busy = 1'b1;

  typedef struct { logic err; logic [63:0] data; int unsigned gcyc; } exp_t;
  exp_t exp_q [N][$];

  typedef struct { logic [63:0] d; int unsigned due; } mrsp_t;
  mrsp_t mq [2][$];
  int unsigned last_due [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int steer(input logic [47:0] a);
    if (a >= BASE0 && a < BASE1) return 0;
    if (a >= BASE1 && a < END1)  return 1;
    return 2;
  endfunction

  function automatic logic [63:0] resp_fn(input int p, input logic [47:0] off, input logic we,
                                          input logic [63:0] wd, input logic [7:0] be);
    logic [7:0] tag;
    tag = (p == 0) ? 8'h3C : 8'hC3;
    return {tag, be, 47'd0, we} ^ {16'd0, off} ^ {wd[31:0], wd[63:32]};
  endfunction

  function automatic logic [47:0] gen_addr();
    int r, kind;
    logic [47:0] off;
    r    = $urandom_range(0, 99);
    kind = (force_port >= 0) ? force_port : ((r < 40) ? 0 : (r < 80) ? 1 : 2);
    off  = 48'($urandom_range(0, 16383)) << 3;
    r    = $urandom_range(0, 9);
    if (r == 0) off = '0;
    else if (r == 1) off = SIZE - 48'd8;
    if (kind == 0) return BASE0 + off;
    if (kind == 1) return BASE1 + off;
    case ($urandom_range(0, 3))
      0:       return BASE0 - 48'd8;
      1:       return END1;
      2:       return END1 + off;
      default: return 48'hFFFF_FFFF_FFF8;
    endcase
  endfunction

  // ---------------- requester agents + arbitration reference ----------------
  bit          pend  [N];
  bit          outst [N];
  logic [47:0] p_addr [N];
  logic        p_we  [N];
  logic [63:0] p_wd  [N];
  logic [7:0]  p_be  [N];
  int          ptr   [2];

  initial begin
    for (int k = 0; k < N; k++) begin
      pend[k] = 0; outst[k] = 0; p_addr[k] = '0; p_we[k] = 0; p_wd[k] = '0; p_be[k] = '0;
    end
    ptr[0] = 0; ptr[1] = 0;
    forever begin
      @(posedge clk_i); #2;
      for (int k = 0; k < N; k++) begin
        if (!rst_ni) pend[k] = 0;
        else if (!pend[k] && !stop_new && $urandom_range(0, 99) < req_pct) begin
          pend[k]   = 1;
          p_addr[k] = gen_addr();
          p_we[k]   = 1'($urandom_range(0, 1));
          p_wd[k]   = {$urandom(), $urandom()};
          p_be[k]   = 8'($urandom_range(0, 255));
        end
        req_i[k]                 = pend[k];
        req_addr_i[k*AW +: AW]   = p_addr[k];
        req_we_i[k]              = p_we[k];
        req_wdata_i[k*DW +: DW]  = p_wd[k];
        req_be_i[k*BW +: BW]     = p_be[k];
      end
      @(negedge clk_i);
      if (!rst_ni) begin
        chk("reset_outputs", {gnt_o, mem_req_o, rsp_valid_o}, '0);
        for (int k = 0; k < N; k++) begin outst[k] = 0; pend[k] = 0; end
        ptr[0] = 0; ptr[1] = 0;
      end else begin
        logic [N-1:0] exp_gnt;
        logic [1:0]   exp_mreq;
        exp_gnt  = '0;
        exp_mreq = '0;
        for (int k = 0; k < N; k++)
          if (pend[k] && !outst[k] && steer(p_addr[k]) == 2) exp_gnt[k] = 1'b1;
        for (int p = 0; p < 2; p++) begin
          int w;
          w = -1;
          for (int i = 0; i < N; i++) begin
            int idx;
            idx = (ptr[p] + i) % N;
            if (w < 0 && pend[idx] && !outst[idx] && steer(p_addr[idx]) == p) w = idx;
          end
          if (w >= 0) begin
            exp_mreq[p] = 1'b1;
            chk($sformatf("mem_addr[%0d]", p), 64'(mem_addr_o[p*AW +: AW]),
                64'(p_addr[w] - ((p == 0) ? BASE0 : BASE1)));
            chk($sformatf("mem_wdata[%0d]", p), mem_wdata_o[p*DW +: DW], p_wd[w]);
            chk($sformatf("mem_we_be[%0d]", p), 64'({mem_we_o[p], mem_be_o[p*BW +: BW]}),
                64'({p_we[w], p_be[w]}));
            if (mem_gnt_i[p]) begin
              exp_gnt[w] = 1'b1;
              ptr[p]     = (w + 1) % N;
            end
          end
        end
        chk("mem_req", 64'(mem_req_o), 64'(exp_mreq));
        chk("gnt", 64'(gnt_o), 64'(exp_gnt));
        for (int k = 0; k < N; k++) begin
          if (rsp_valid_o[k]) outst[k] = 0;
          if (exp_gnt[k]) begin
            exp_t e;
            int   p;
            p      = steer(p_addr[k]);
            e.err  = (p == 2);
            e.data = (p == 2) ? 64'd0 :
                     resp_fn(p, p_addr[k] - ((p == 0) ? BASE0 : BASE1), p_we[k], p_wd[k], p_be[k]);
            e.gcyc = cyc;
            exp_q[k].push_back(e);
            outst[k] = 1;
            pend[k]  = 0;
          end
        end
      end
      tb_busy = 0;
      for (int k = 0; k < N; k++) if (pend[k] || outst[k]) tb_busy = 1;
    end
  end

  // ---------------- memory model: random grant, in-order random latency ----------------
  initial begin
    last_due[0] = 0; last_due[1] = 0;
    forever begin
      @(posedge clk_i); #2;
      for (int p = 0; p < 2; p++) begin
        mem_rvalid_i[p]          = 1'b0;
        mem_rdata_i[p*DW +: DW]  = '0;
        if (!rst_ni) begin
          mem_gnt_i[p] = 1'b0;
          mq[p].delete();
        end else begin
          mem_gnt_i[p] = (p == 0 && stall0) ? 1'b0 : ($urandom_range(0, 99) < gnt_pct);
          if (mq[p].size() > 0 && mq[p][0].due <= cyc) begin
            mrsp_t r;
            r = mq[p].pop_front();
            mem_rvalid_i[p]         = 1'b1;
            mem_rdata_i[p*DW +: DW] = r.d;
          end
        end
      end
      @(negedge clk_i);
      for (int p = 0; p < 2; p++) begin
        if (!rst_ni) begin
          mq[p].delete();
          last_due[p] = 0;
        end else if (mem_req_o[p] && mem_gnt_i[p]) begin
          mrsp_t r;
          r.due = cyc + $urandom_range(1, lat_max);
          if (r.due <= last_due[p]) r.due = last_due[p] + 1;
          last_due[p] = r.due;
          r.d = resp_fn(p, mem_addr_o[p*AW +: AW], mem_we_o[p],
                        mem_wdata_o[p*DW +: DW], mem_be_o[p*BW +: BW]);
          mq[p].push_back(r);
        end
      end
    end
  end

  // ---------------- response monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        for (int k = 0; k < N; k++) exp_q[k].delete();
      end else begin
        for (int k = 0; k < N; k++) begin
          if (rsp_valid_o[k]) begin
            if (exp_q[k].size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL spurious_rsp[%0d] at cycle %0d: got valid expected none", k, cyc);
            end else begin
              exp_t e;
              e = exp_q[k].pop_front();
              chk($sformatf("rsp_err[%0d]", k), 64'(rsp_err_o[k]), 64'(e.err));
              chk($sformatf("rsp_rdata[%0d]", k), rsp_rdata_o[k*DW +: DW], e.data);
              if (e.err) chk($sformatf("err_rsp_cycle[%0d]", k), 64'(cyc), 64'(e.gcyc + 1));
            end
          end else begin
            chk($sformatf("idle_rdata[%0d]", k), rsp_rdata_o[k*DW +: DW], 64'd0);
          end
        end
      end
    end
  end

  // ---------------- sequence ----------------
  initial begin
    int n;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    repeat (1500) @(posedge clk_i);

    gnt_pct = 100; lat_max = 1; force_port = 0; req_pct = 100;
    repeat (200) @(posedge clk_i);

    force_port = -1; gnt_pct = 80; lat_max = 3; req_pct = 50;
    stall0 = 1'b1;
    repeat (3) @(posedge clk_i);
    stall0 = 1'b0;
    repeat (50) @(posedge clk_i);
    stall0 = 1'b1;
    repeat (20) @(posedge clk_i);
    stall0 = 1'b0;

    gnt_pct = 100; lat_max = 8; req_pct = 70;
    repeat (40) @(posedge clk_i);
    #1 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    gnt_pct = 60; lat_max = 6; req_pct = 40;
    repeat (800) @(posedge clk_i);

    stop_new = 1'b1;
    repeat (2) @(posedge clk_i);
    n = 0;
    while (tb_busy && n < 400) begin
      @(posedge clk_i);
      n++;
    end
    @(negedge clk_i);
    vectors++;
    if (tb_busy) begin
      miscompares++;
      $display("FAIL drain_timeout: requests still pending/outstanding after %0d cycles", n);
    end
    n = 0;
    for (int k = 0; k < N; k++) n += exp_q[k].size();
    chk("scoreboard_empty", 64'(n), 64'd0);
    chk("memq_empty", 64'(mq[0].size() + mq[1].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/l2_dual_port_arbiter.md
Name: l2_dual_port_arbiter

Overview:
- Shares the two contiguous L2 ports (port 0 at Port0Base, port 1 directly above it) among NumReq host-side requesters.
- Per-port round-robin arbitration, address-based port steering and in-order response routing.
- Out-of-window accesses receive an error response.
- Sits between the SoC interconnect demux outputs and the L2 memory controller ports.

Parameters:
- NumReq, 4, number of requesters (≥2).
- AddrWidth, 48, address width.
- DataWidth, 64, data width; BeWidth = DataWidth/8.
- Port0Base, 48'h7800_0000, base of L2 port 0.
- PortSize, 48'h0002_0000, size of each port (power of two); port 1 base = Port0Base + PortSize.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NumReq  per-requester request
- req_addr_i  in  NumReq*AddrWidth  byte address
- req_we_i  in  NumReq  write enable
- req_wdata_i  in  NumReq*DataWidth  write data
- req_be_i  in  NumReq*BeWidth  byte enables
- gnt_o  out  NumReq  grant
- rsp_valid_o  out  NumReq  response valid (one cycle; no backpressure)
- rsp_rdata_o  out  NumReq*DataWidth  read data
- rsp_err_o  out  NumReq  error flag, qualified by rsp_valid_o
- mem_req_o  out  2  port request
- mem_gnt_i  in  2  port grant
- mem_addr_o  out  2*AddrWidth  offset within port (addr − port base)
- mem_we_o  out  2  write enable
- mem_wdata_o  out  2*DataWidth  write data
- mem_be_o  out  2*BeWidth  byte enables
- mem_rvalid_i  in  2  port response (reads and writes, in order per port)
- mem_rdata_i  in  2*DataWidth  port read data

Behaviour:
- Reset: all registered outputs 0. Round-robin pointers 0. ID FIFOs empty. Outstanding flags clear.
- Steering:
  - addr in [Port0Base, Port0Base+PortSize) → port 0.
  - addr in [Port0Base+PortSize, Port0Base+2*PortSize) → port 1.
  - Otherwise → error path.
- One outstanding transaction per requester. While outst[k]=1, req_i[k] is ignored (no gnt). outst[k] is set on the gnt cycle and cleared on the rsp_valid cycle.
- Requester contract: hold req/addr/we/wdata/be stable until gnt.
- Per-port arbitration (combinational each cycle):
  - Eligible = req_i & ~outst & steered-to-port.
  - Winner = first eligible index ≥ ptr, wrapping.
  - mem_req_o[p] = |eligible. Address, data, we and be are muxed from the winner.
  - gnt_o[winner] = mem_gnt_i[p], same cycle.
  - On handshake: ptr ← winner+1 mod NumReq, and the winner ID is pushed into the port-p ID FIFO.
  - Winner may change between cycles while mem_gnt_i is low; the memory side must tolerate this.
- ID FIFO per port: depth NumReq, never overflows by construction. On mem_rvalid_i[p], pop the head ID h and drive rsp_valid_o[h]=1, rsp_rdata_o[h]=mem_rdata_i[p], rsp_err_o[h]=0, combinationally in the same cycle. Push and pop in the same cycle are both honoured. mem_rvalid_i with an empty FIFO is a protocol error: ignore it and assert an SVA.
- Error path: gnt_o[k]=1 in the same cycle, no port access. The next cycle drives rsp_valid_o[k]=1, rsp_err_o[k]=1, rsp_rdata_o[k]=0 (registered).
- Simultaneous events:
  - Both ports may grant different requesters in the same cycle.
  - Both ports may respond in the same cycle; the heads are distinct because of the one-outstanding rule.
  - An error response and a port response cannot target the same requester.
- rsp_rdata_o[k]=0 whenever rsp_valid_o[k]=0.
- Reset mid-operation: FIFOs, flags and pointers clear immediately. Any in-flight memory responses are lost; the memory is reset by the same rst_ni.

Test Plan:
- Reset: rst_ni=0 → gnt_o=0, mem_req_o=0, rsp_valid_o=0; ptrs 0 after release.
- Steering: req0 read 0x7800_0010 → mem_req_o=2'b01, mem_addr_o[0]=0x10. Then req1 read 0x7802_0008 → mem_req_o=2'b10, mem_addr_o[1]=0x8. rdata 0xA5A5 returned on rsp_rdata_o[1] the cycle mem_rvalid_i[1]=1.
- Round-robin: req0–3 all hit port 0 continuously, mem_gnt_i=1, rvalid 1 cycle later → grants 0,1,2,3,0 in consecutive cycles. No requester is granted again before its rsp.
- Error: req2 write to 0x7804_0000 → gnt_o[2] same cycle, no mem_req_o. Next cycle rsp_valid_o[2]=1, rsp_err_o[2]=1, rsp_rdata_o=0.
- Out-of-order ports: req0→port0 with 5-cycle latency, req1→port1 with 1-cycle latency → req1 response first, each routed to the correct requester. Simultaneous rvalid on both ports routes both correctly.
- Stall and reset: mem_gnt_i[0]=0 for 3 cycles → no gnt, ptr unchanged. Assert rst_ni=0 with 2 responses outstanding → FIFOs empty, outst clear, no spurious rsp_valid_o.
